// File: rtl/pipe_event_monitor_if.sv
// Bundle of the pipeline taps, trace stream and monitor results shared by
// pipe_event_monitor (slave) and whatever drives or observes it (master).
interface pipe_event_monitor_if #(
    parameter int CNT_W = 32
);
    logic             reg_write_w;
    logic [4:0]       rd_w;
    logic [31:0]      result_w;
    logic [31:0]      pc_plus4_w;
    logic             mem_write_m;
    logic [31:0]      alu_result_m;
    logic [31:0]      write_data_m;
    logic             pc_src_e;
    logic [31:0]      pc_target_e;
    logic             trace_valid;
    logic             trace_ready;
    logic [70:0]      trace_data;
    logic [CNT_W-1:0] wb_cnt;
    logic [CNT_W-1:0] st_cnt;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [1:0]       status;
    logic             done;
    logic [31:0]      mailbox_data;

    modport master (
        output reg_write_w, rd_w, result_w, pc_plus4_w,
        output mem_write_m, alu_result_m, write_data_m,
        output pc_src_e, pc_target_e, trace_ready,
        input  trace_valid, trace_data, wb_cnt, st_cnt, br_cnt, drop_cnt,
        input  status, done, mailbox_data
    );

    modport slave (
        input  reg_write_w, rd_w, result_w, pc_plus4_w,
        input  mem_write_m, alu_result_m, write_data_m,
        input  pc_src_e, pc_target_e, trace_ready,
        output trace_valid, trace_data, wb_cnt, st_cnt, br_cnt, drop_cnt,
        output status, done, mailbox_data
    );
endinterface

// File: rtl/pipe_event_monitor.sv
// Pipeline event monitor: traces WB/store/branch events into a FWFT FIFO,
// counts them with saturation and resolves PASS/FAIL/TIMEOUT from a mailbox store.
module pipe_event_monitor #(
    parameter int          DEPTH          = 16,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] MAILBOX_ADDR   = 32'h0000_0100,
    parameter logic [31:0] PASS_VALUE     = 32'd1,
    parameter int          TIMEOUT_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_event_monitor_if.slave  mon
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    state_t           state_r;
    logic             done_r;
    logic [31:0]      mailbox_data_r;
    logic [31:0]      cyc_r;
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [70:0]      mem_r [DEPTH];
    logic             trace_valid_r;
    logic [70:0]      trace_data_r;
    logic [CNT_W-1:0] wb_cnt_r;
    logic [CNT_W-1:0] st_cnt_r;
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic             run_s;
    logic             wb_q_s;
    logic             st_q_s;
    logic             br_q_s;
    logic             mbox_hit_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic [70:0]      push_data_s;
    logic [1:0]       n_q_s;
    logic [1:0]       n_drop_s;
    logic [AW:0]      wr_ptr_n_s;
    logic [AW:0]      rd_ptr_n_s;
    logic             empty_n_s;
    logic [70:0]      head_n_s;

    // Event qualification, push arbitration and drop accounting
    always_comb begin
        run_s      = (state_r == ST_RUN);
        wb_q_s     = run_s & mon.reg_write_w & (mon.rd_w != 5'd0);
        st_q_s     = run_s & mon.mem_write_m;
        br_q_s     = run_s & mon.pc_src_e;
        mbox_hit_s = st_q_s & (mon.alu_result_m == MAILBOX_ADDR);
        full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s      = trace_valid_r & mon.trace_ready;
        // A pop in the same cycle frees the slot the push needs
        push_s     = (wb_q_s | st_q_s | br_q_s) & (~full_s | pop_s);
        if (wb_q_s) begin
            push_data_s = {2'b01, mon.rd_w, mon.pc_plus4_w - 32'd4, mon.result_w};
        end else if (st_q_s) begin
            push_data_s = {2'b10, 5'd0, mon.alu_result_m, mon.write_data_m};
        end else begin
            push_data_s = {2'b11, 5'd0, mon.pc_target_e, 32'd0};
        end
        n_q_s = {1'b0, wb_q_s} + {1'b0, st_q_s} + {1'b0, br_q_s};
        if (push_s) begin
            n_drop_s = n_q_s - 2'd1;
        end else begin
            n_drop_s = n_q_s;
        end
    end

    // Next-cycle FIFO head so trace_valid/trace_data can be registered
    always_comb begin
        if (pop_s) begin
            rd_ptr_n_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_n_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_n_s = wr_ptr_r;
        end
        empty_n_s = (rd_ptr_n_s == wr_ptr_n_s);
        if (empty_n_s) begin
            head_n_s = trace_data_r;
        end else if (push_s && (rd_ptr_n_s == wr_ptr_r)) begin
            head_n_s = push_data_s;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s[AW-1:0]];
        end
    end

    // FIFO storage; contents are meaningless until the pointers cover them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
        end
    end

    // FIFO pointers and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            trace_valid_r <= 1'b0;
            trace_data_r  <= 71'd0;
        end else begin
            wr_ptr_r      <= wr_ptr_n_s;
            rd_ptr_r      <= rd_ptr_n_s;
            trace_valid_r <= ~empty_n_s;
            trace_data_r  <= head_n_s;
        end
    end

    // Saturating event and drop counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cnt_r   <= '0;
            st_cnt_r   <= '0;
            br_cnt_r   <= '0;
            drop_cnt_r <= '0;
        end else begin
            wb_cnt_r   <= sat_add(wb_cnt_r, {1'b0, wb_q_s});
            st_cnt_r   <= sat_add(st_cnt_r, {1'b0, st_q_s});
            br_cnt_r   <= sat_add(br_cnt_r, {1'b0, br_q_s});
            drop_cnt_r <= sat_add(drop_cnt_r, n_drop_s);
        end
    end

    // Test-outcome FSM with watchdog; the mailbox store beats a same-cycle timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_RUN;
            done_r         <= 1'b0;
            mailbox_data_r <= 32'd0;
            cyc_r          <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cyc_r <= cyc_r + 32'd1;
                    if (mbox_hit_s) begin
                        mailbox_data_r <= mon.write_data_m;
                        done_r         <= 1'b1;
                        if (mon.write_data_m == PASS_VALUE) begin
                            state_r <= ST_PASS;
                        end else begin
                            state_r <= ST_FAIL;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (cyc_r == TO_LAST)) begin
                        state_r <= ST_TIMEOUT;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_FAIL;
                    done_r  <= 1'b1;
                end
            endcase
        end
    end

    assign mon.trace_valid  = trace_valid_r;
    assign mon.trace_data   = trace_data_r;
    assign mon.wb_cnt       = wb_cnt_r;
    assign mon.st_cnt       = st_cnt_r;
    assign mon.br_cnt       = br_cnt_r;
    assign mon.drop_cnt     = drop_cnt_r;
    assign mon.status       = state_r;
    assign mon.done         = done_r;
    assign mon.mailbox_data = mailbox_data_r;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Directed bench for pipe_event_monitor: trace, arbitration, FIFO full/drain,
// mailbox outcome, watchdog and asynchronous reset.
module tb_pipe_event_monitor;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipe_event_monitor_if #(.CNT_W(32)) ifa ();
    pipe_event_monitor_if #(.CNT_W(32)) ifb ();

    pipe_event_monitor #(.DEPTH(DEPTH), .CNT_W(32)) dut_a (
        .clk (clk), .rst (rst_a), .mon (ifa.slave)
    );

    pipe_event_monitor #(.DEPTH(4), .CNT_W(32), .TIMEOUT_CYCLES(8)) dut_b (
        .clk (clk), .rst (rst_b), .mon (ifb.slave)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] ent(input logic [1:0] t, input logic [4:0] rd,
                                        input logic [31:0] a, input logic [31:0] d);
        return {t, rd, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic wb, input logic [4:0] rd, input logic [31:0] res,
                           input logic [31:0] pc4, input logic st, input logic [31:0] addr,
                           input logic [31:0] data, input logic br, input logic [31:0] tgt);
        ifa.reg_write_w  = wb;
        ifa.rd_w         = rd;
        ifa.result_w     = res;
        ifa.pc_plus4_w   = pc4;
        ifa.mem_write_m  = st;
        ifa.alu_result_m = addr;
        ifa.write_data_m = data;
        ifa.pc_src_e     = br;
        ifa.pc_target_e  = tgt;
    endtask

    task automatic drive_b(input logic wb, input logic [4:0] rd, input logic st,
                           input logic [31:0] addr, input logic [31:0] data);
        ifb.reg_write_w  = wb;
        ifb.rd_w         = rd;
        ifb.result_w     = 32'd5;
        ifb.pc_plus4_w   = 32'h40;
        ifb.mem_write_m  = st;
        ifb.alu_result_m = addr;
        ifb.write_data_m = data;
        ifb.pc_src_e     = 1'b0;
        ifb.pc_target_e  = 32'd0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        drive_b(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        ifa.trace_ready = 1'b0;
        ifb.trace_ready = 1'b0;
        step();
        step();
        check_eq("rst_valid", 128'(ifa.trace_valid), 128'd0);
        check_eq("rst_data", 128'(ifa.trace_data), 128'd0);
        check_eq("rst_cnts", {ifa.wb_cnt, ifa.st_cnt, ifa.br_cnt, ifa.drop_cnt}, 128'd0);
        check_eq("rst_status", {ifa.status, ifa.done, ifa.mailbox_data}, 128'd0);
        rst_a = 1'b0;

        // single WB event
        drive_a(1'b1, 5'd5, 32'd42, 32'h14, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        step();
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_eq("t1_valid", 128'(ifa.trace_valid), 128'd1);
        check_eq("t1_data", 128'(ifa.trace_data), 128'(ent(2'b01, 5'd5, 32'h10, 32'd42)));
        check_eq("t1_wb_cnt", 128'(ifa.wb_cnt), 128'd1);
        ifa.trace_ready = 1'b1;
        step();
        ifa.trace_ready = 1'b0;
        check_eq("t1_popped", 128'(ifa.trace_valid), 128'd0);
        check_eq("t1_hold", 128'(ifa.trace_data), 128'(ent(2'b01, 5'd5, 32'h10, 32'd42)));

        // WB + STORE + BRANCH in one cycle, and rd=0 WB is ignored
        drive_a(1'b1, 5'd3, 32'hAA, 32'h24, 1'b1, 32'h40, 32'h55, 1'b1, 32'h80);
        step();
        drive_a(1'b1, 5'd0, 32'h77, 32'h30, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_eq("t2_data", 128'(ifa.trace_data), 128'(ent(2'b01, 5'd3, 32'h20, 32'hAA)));
        check_eq("t2_cnts", {ifa.wb_cnt, ifa.st_cnt, ifa.br_cnt, ifa.drop_cnt},
                 {32'd2, 32'd1, 32'd1, 32'd2});
        ifa.trace_ready = 1'b1;
        step();
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        ifa.trace_ready = 1'b0;
        check_eq("t2_rd0_valid", 128'(ifa.trace_valid), 128'd0);
        check_eq("t2_rd0_cnt", {ifa.wb_cnt, ifa.drop_cnt}, {32'd2, 32'd2});

        // DEPTH+2 WB events with no consumer
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive_a(1'b1, 5'(i + 1), 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
            step();
        end
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_eq("t3_drop", 128'(ifa.drop_cnt), 128'd4);
        check_eq("t3_head", 128'(ifa.trace_data), 128'(ent(2'b01, 5'd1, 32'hFFC, 32'd0)));

        // full FIFO: pop and push in the same cycle
        ifa.trace_ready = 1'b1;
        drive_a(1'b1, 5'd7, 32'd100, 32'h2004, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        step();
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        ifa.trace_ready = 1'b0;
        check_eq("t4_drop", 128'(ifa.drop_cnt), 128'd4);
        check_eq("t4_wb_cnt", 128'(ifa.wb_cnt), 128'd21);
        for (int k = 0; k < DEPTH; k++) begin
            if (k < DEPTH - 1) begin
                check_eq($sformatf("drain%0d", k), {ifa.trace_valid, ifa.trace_data},
                         {1'b1, ent(2'b01, 5'(k + 2), 32'h1000 + 32'(4 * k), 32'(k + 1))});
            end else begin
                check_eq("drain_last", {ifa.trace_valid, ifa.trace_data},
                         {1'b1, ent(2'b01, 5'd7, 32'h2000, 32'd100)});
            end
            ifa.trace_ready = 1'b1;
            step();
            ifa.trace_ready = 1'b0;
        end
        check_eq("t4_empty", 128'(ifa.trace_valid), 128'd0);

        // mailbox PASS, then events are frozen
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h100, 32'd1, 1'b0, 32'd0);
        step();
        drive_a(1'b1, 5'd9, 32'd9, 32'h50, 1'b0, 32'd0, 32'd0, 1'b1, 32'h90);
        check_eq("t5_pass", {ifa.status, ifa.done, ifa.mailbox_data}, {2'b01, 1'b1, 32'd1});
        check_eq("t5_st_cnt", 128'(ifa.st_cnt), 128'd2);
        check_eq("t5_trace", 128'(ifa.trace_data), 128'(ent(2'b10, 5'd0, 32'h100, 32'd1)));
        step();
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_eq("t5_frozen", {ifa.wb_cnt, ifa.br_cnt, ifa.drop_cnt}, {32'd21, 32'd1, 32'd4});
        check_eq("t5_nopush", 128'(ifa.trace_data), 128'(ent(2'b10, 5'd0, 32'h100, 32'd1)));
        #2;
        rst_a = 1'b1;
        #1;
        check_eq("a_rst_mid", {ifa.trace_valid, ifa.wb_cnt, ifa.status, ifa.done, ifa.mailbox_data},
                 128'd0);
        step();
        rst_a = 1'b0;

        // mailbox FAIL
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h100, 32'd7, 1'b0, 32'd0);
        step();
        drive_a(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_eq("t5_fail", {ifa.status, ifa.done, ifa.mailbox_data}, {2'b10, 1'b1, 32'd7});

        // watchdog with TIMEOUT_CYCLES=8
        rst_b = 1'b0;
        repeat (7) step();
        check_eq("t6_run7", {ifb.status, ifb.done}, {2'b00, 1'b0});
        step();
        check_eq("t6_timeout", {ifb.status, ifb.done}, {2'b11, 1'b1});
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        repeat (7) step();
        drive_b(1'b0, 5'd0, 1'b1, 32'h100, 32'd1);
        step();
        drive_b(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_eq("t6_mbox_wins", {ifb.status, ifb.done}, {2'b01, 1'b1});

        // asynchronous reset mid-run
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        drive_b(1'b1, 5'd4, 1'b0, 32'd0, 32'd0);
        step();
        drive_b(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_eq("b_pre_rst", {ifb.trace_valid, ifb.wb_cnt}, {1'b1, 32'd1});
        #2;
        rst_b = 1'b1;
        #1;
        check_eq("b_rst_mid", {ifb.trace_valid, ifb.trace_data, ifb.wb_cnt, ifb.status, ifb.done},
                 128'd0);
        rst_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
